// File: rtl/score_ssd_driver_if.sv
// rtl/score_ssd_driver_if.sv - score input / SSD output bundle for score_ssd_driver
interface score_ssd_if;
   logic [15:0] score;
   logic        hold;
   logic [7:0]  an;
   logic [6:0]  ssd;
   logic        dp;
   logic [19:0] bcd;
   logic        conv_done;

   modport master (
      output score, hold,
      input  an, ssd, dp, bcd, conv_done
   );

   modport slave (
      input  score, hold,
      output an, ssd, dp, bcd, conv_done
   );
endinterface

// File: rtl/score_ssd_driver.sv
// rtl/score_ssd_driver.sv - binary score to BCD (double-dabble) with multiplexed 8-digit SSD
module score_ssd_driver #(
   parameter int REFRESH_BITS = 18
) (
   input  logic        clk,
   input  logic        rst,
   score_ssd_if.slave  bus
);

   typedef enum logic [1:0] {CAPTURE, SHIFT, COMMIT} state_t;

   state_t      state, state_nx;
   logic [15:0] shreg, shreg_nx;
   logic [19:0] scratch, scratch_nx;
   logic [19:0] adj;
   logic [3:0]  bit_cnt, bit_cnt_nx;
   logic [19:0] bcd_q, bcd_nx;
   logic        done_q, done_nx;

   logic [REFRESH_BITS-1:0] refresh_q;
   logic [2:0]  sel;
   logic [3:0]  nib;
   logic        blank;
   logic [7:0]  an_q, an_nx;
   logic [6:0]  ssd_q, ssd_nx;

   function automatic logic [6:0] glyph(input logic [3:0] n);
      case (n)
         4'd0:    glyph = 7'b1000000;
         4'd1:    glyph = 7'b1111001;
         4'd2:    glyph = 7'b0100100;
         4'd3:    glyph = 7'b0110000;
         4'd4:    glyph = 7'b0011001;
         4'd5:    glyph = 7'b0010010;
         4'd6:    glyph = 7'b0000010;
         4'd7:    glyph = 7'b1111000;
         4'd8:    glyph = 7'b0000000;
         4'd9:    glyph = 7'b0010000;
         default: glyph = 7'h7F;
      endcase
   endfunction

   // Add-3 correction of every scratch nibble that is 5 or more, ahead of the shift
   always_comb begin
      adj = scratch;
      for (int i = 0; i < 5; i++) begin
         if (scratch[4*i +: 4] >= 4'd5)
            adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
      end
   end

   // Conversion state register and committed result
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= CAPTURE;
         shreg   <= '0;
         scratch <= '0;
         bit_cnt <= '0;
         bcd_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state   <= state_nx;
         shreg   <= shreg_nx;
         scratch <= scratch_nx;
         bit_cnt <= bit_cnt_nx;
         bcd_q   <= bcd_nx;
         done_q  <= done_nx;
      end
   end

   // Next-state: sample score, shift one bit per clock for 16 clocks, then commit
   always_comb begin
      state_nx   = state;
      shreg_nx   = shreg;
      scratch_nx = scratch;
      bit_cnt_nx = bit_cnt;
      bcd_nx     = bcd_q;
      done_nx    = 1'b0;
      case (state)
         CAPTURE: begin
            if (!bus.hold) begin
               shreg_nx   = bus.score;
               scratch_nx = '0;
               bit_cnt_nx = '0;
               state_nx   = SHIFT;
            end
         end
         SHIFT: begin
            {scratch_nx, shreg_nx} = {adj, shreg} << 1;
            bit_cnt_nx = bit_cnt + 4'd1;
            if (bit_cnt == 4'd15)
               state_nx = COMMIT;
         end
         COMMIT: begin
            bcd_nx   = scratch;
            done_nx  = 1'b1;
            state_nx = CAPTURE;
         end
         default: state_nx = CAPTURE;
      endcase
   end

   assign sel = refresh_q[REFRESH_BITS-1 -: 3];

   // Pick the digit for the current slot and decide leading-zero blanking
   always_comb begin
      nib   = 4'd0;
      blank = 1'b1;
      case (sel)
         3'd0: begin nib = bcd_q[3:0];   blank = 1'b0;                end
         3'd1: begin nib = bcd_q[7:4];   blank = (bcd_q[19:4]  == '0); end
         3'd2: begin nib = bcd_q[11:8];  blank = (bcd_q[19:8]  == '0); end
         3'd3: begin nib = bcd_q[15:12]; blank = (bcd_q[19:12] == '0); end
         3'd4: begin nib = bcd_q[19:16]; blank = (bcd_q[19:16] == '0); end
         default: begin nib = 4'd0;      blank = 1'b1;                end
      endcase
      an_nx  = blank ? 8'hFF : ~(8'b1 << sel);
      ssd_nx = blank ? 7'h7F : glyph(nib);
   end

   // Free-running refresh counter and registered anode/cathode drive
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         refresh_q <= '0;
         an_q      <= 8'b11111110;
         ssd_q     <= 7'b1000000;
      end else begin
         refresh_q <= refresh_q + 1'b1;
         an_q      <= an_nx;
         ssd_q     <= ssd_nx;
      end
   end

   assign bus.an        = an_q;
   assign bus.ssd       = ssd_q;
   assign bus.dp        = 1'b1;
   assign bus.bcd       = bcd_q;
   assign bus.conv_done = done_q;

endmodule
